// File: rtl/mem_loader.sv
// Byte-stream packet loader: parses CMD/ADDR/LEN headers and writes assembled
// words into the instruction, weight or XY memories, or pulses start.
module mem_loader #(
    parameter int WORD_BYTES = 2,
    parameter int NU_COUNT   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    buffer_empty,
    input  logic [7:0]              buffer_data,
    output logic                    buffer_read_enable,
    output logic [15:0]             mem_write_addr,
    output logic [8*WORD_BYTES-1:0] mem_write_data,
    output logic                    inst_write_enable,
    output logic [NU_COUNT-1:0]     w_write_enable,
    output logic                    xy_write_enable,
    output logic                    start,
    output logic                    busy
);

    localparam int DW = 8 * WORD_BYTES;
    localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR_H,
        S_ADDR_L,
        S_LEN_H,
        S_LEN_L,
        S_DATA
    } state_t;

    state_t        state;
    logic [1:0]    target;
    logic [5:0]    nu;
    logic [15:0]   addr;
    logic [15:0]   word_cnt;
    logic [BW-1:0] byte_cnt;
    logic [DW-1:0] asm_word;
    logic [DW-1:0] next_word;
    logic [15:0]   len;
    logic          pop;

    assign pop                = ~buffer_empty & ~reset;
    assign buffer_read_enable = pop;
    assign busy               = (state != S_CMD);
    assign next_word          = DW'({asm_word, buffer_data});
    assign len                = {word_cnt[15:8], buffer_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_CMD;
            target            <= 2'd0;
            nu                <= 6'd0;
            addr              <= 16'd0;
            word_cnt          <= 16'd0;
            byte_cnt          <= '0;
            asm_word          <= '0;
            mem_write_addr    <= 16'd0;
            mem_write_data    <= '0;
            inst_write_enable <= 1'b0;
            w_write_enable    <= '0;
            xy_write_enable   <= 1'b0;
            start             <= 1'b0;
        end else begin
            inst_write_enable <= 1'b0;
            w_write_enable    <= '0;
            xy_write_enable   <= 1'b0;
            start             <= 1'b0;
            if (pop) begin
                unique case (state)
                    S_CMD: begin
                        target <= buffer_data[7:6];
                        nu     <= buffer_data[5:0];
                        if (buffer_data[7:6] == 2'b11) start <= 1'b1;
                        else state <= S_ADDR_H;
                    end
                    S_ADDR_H: begin
                        addr[15:8] <= buffer_data;
                        state      <= S_ADDR_L;
                    end
                    S_ADDR_L: begin
                        addr[7:0] <= buffer_data;
                        state     <= S_LEN_H;
                    end
                    S_LEN_H: begin
                        word_cnt[15:8] <= buffer_data;
                        state          <= S_LEN_L;
                    end
                    S_LEN_L: begin
                        word_cnt <= len;
                        byte_cnt <= '0;
                        state    <= (len == 16'd0) ? S_CMD : S_DATA;
                    end
                    S_DATA: begin
                        asm_word <= next_word;
                        if (byte_cnt == BW'(WORD_BYTES - 1)) begin
                            // Word complete: present it next cycle on one strobe.
                            mem_write_addr <= addr;
                            mem_write_data <= next_word;
                            addr           <= addr + 16'd1;
                            byte_cnt       <= '0;
                            word_cnt       <= word_cnt - 16'd1;
                            unique case (target)
                                2'b00: inst_write_enable <= 1'b1;
                                2'b01: if (int'(nu) < NU_COUNT)
                                    w_write_enable <= NU_COUNT'(1) << nu;
                                2'b10: xy_write_enable <= 1'b1;
                                default: ;
                            endcase
                            if (word_cnt == 16'd1) state <= S_CMD;
                        end else begin
                            byte_cnt <= byte_cnt + BW'(1);
                        end
                    end
                    default: state <= S_CMD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed-stream bench for mem_loader: a packet-level model predicts the
// writes and start pulses, and a negedge monitor compares every strobe cycle.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        buffer_empty;
    logic [7:0]  buffer_data;
    logic        buffer_read_enable;
    logic [15:0] mem_write_addr;
    logic [15:0] mem_write_data;
    logic        inst_write_enable;
    logic [3:0]  w_write_enable;
    logic        xy_write_enable;
    logic        start;
    logic        busy;

    mem_loader #(.WORD_BYTES(2), .NU_COUNT(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .buffer_empty       (buffer_empty),
        .buffer_data        (buffer_data),
        .buffer_read_enable (buffer_read_enable),
        .mem_write_addr     (mem_write_addr),
        .mem_write_data     (mem_write_data),
        .inst_write_enable  (inst_write_enable),
        .w_write_enable     (w_write_enable),
        .xy_write_enable    (xy_write_enable),
        .start              (start),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic [5:0]  nu;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   starts_seen = 0;
    int   pops = 0;
    logic [7:0] stream[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Packet-level model: walks the byte list and lists every memory write.
    function automatic int model(input logic [7:0] b[$]);
        int i = 0;
        int n_start = 0;
        logic [7:0] cmd;
        logic [15:0] a, len;
        wr_t w;
        while (i < b.size()) begin
            cmd = b[i];
            i++;
            if (cmd[7:6] == 2'b11) begin
                n_start++;
                continue;
            end
            a   = {b[i], b[i+1]};
            len = {b[i+2], b[i+3]};
            i += 4;
            for (int k = 0; k < int'(len); k++) begin
                w.kind = cmd[7:6];
                w.nu   = cmd[5:0];
                w.addr = a;
                w.data = {b[i], b[i+1]};
                i += 2;
                if (!(cmd[7:6] == 2'b01 && cmd[5:0] >= 6'd4)) exp_q.push_back(w);
                a = a + 16'd1;
            end
        end
        return n_start;
    endfunction

    always @(posedge clk) if (buffer_read_enable) pops <= pops + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (start) starts_seen++;
            if (inst_write_enable || xy_write_enable || (w_write_enable != 4'd0)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write",
                          {26'd0, inst_write_enable, w_write_enable, xy_write_enable}, 32'd0);
                end else begin
                    wr_t e;
                    logic [3:0] ew;
                    e  = exp_q.pop_front();
                    ew = (e.kind == 2'b01) ? 4'(4'd1 << e.nu) : 4'd0;
                    check("strobes",
                          {26'd0, inst_write_enable, w_write_enable, xy_write_enable},
                          {26'd0, e.kind == 2'b00, ew, e.kind == 2'b10});
                    check("addr", {16'd0, mem_write_addr}, {16'd0, e.addr});
                    check("data", {16'd0, mem_write_data}, {16'd0, e.data});
                end
            end
        end
    end

    task automatic send(input bit gaps);
        for (int i = 0; i < stream.size(); i++) begin
            if (gaps) begin
                buffer_empty = 1'b1;
                @(posedge clk); #1;
            end
            buffer_empty = 1'b0;
            buffer_data  = stream[i];
            @(posedge clk); #1;
        end
        buffer_empty = 1'b1;
    endtask

    task automatic run(input string name, input bit gaps);
        int ns, s0;
        s0 = starts_seen;
        ns = model(stream);
        send(gaps);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_starts"}, starts_seen - s0, ns);
        check({name, "_busy"}, {31'd0, busy}, 0);
        exp_q.delete();
    endtask

    initial begin
        int p0;
        reset        = 1'b1;
        buffer_empty = 1'b1;
        buffer_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        buffer_empty = 1'b0;
        #1;
        check("rst_read_enable", {31'd0, buffer_read_enable}, 0);
        check("rst_addr", {16'd0, mem_write_addr}, 0);
        check("rst_data", {16'd0, mem_write_data}, 0);
        check("rst_strobes", {26'd0, inst_write_enable, w_write_enable, xy_write_enable}, 0);
        check("rst_start_busy", {30'd0, start, busy}, 0);
        buffer_empty = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        stream = '{8'h00, 8'h00, 8'h10, 8'h00, 8'h02, 8'hAB, 8'hCD, 8'h12, 8'h34};
        void'(model(stream));
        check("model_pin_addr0", {16'd0, exp_q[0].addr}, 32'h0010);
        check("model_pin_data1", {16'd0, exp_q[1].data}, 32'h1234);
        exp_q.delete();
        run("inst", 1'b0);
        run("inst_gaps", 1'b1);

        stream = '{8'h42, 8'h00, 8'h00, 8'h00, 8'h01, 8'hBE, 8'hEF};
        run("weight", 1'b0);

        stream = '{8'h80, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22};
        run("xy_wrap", 1'b0);

        stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0};
        p0 = starts_seen;
        send(1'b0);
        check("start_pulse", {31'd0, start}, 1);
        @(posedge clk); #1;
        check("start_width", {31'd0, start}, 0);
        check("start_count", starts_seen - p0, 1);

        stream = '{8'h47, 8'h00, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hBB};
        p0 = pops;
        run("bad_nu", 1'b0);
        check("bad_nu_pops", pops - p0, 7);

        stream = '{8'h00, 8'h00, 8'h10, 8'h00, 8'h02, 8'hAB};
        send(1'b0);
        check("mid_busy", {31'd0, busy}, 1);
        reset = 1'b1;
        buffer_empty = 1'b0;
        #1;
        check("mid_rst_read_enable", {31'd0, buffer_read_enable}, 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        buffer_empty = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        stream = '{8'hC0};
        run("after_reset", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
